// File: rtl/median_pkg.sv
// Shared types and constants for the 5x5 median filter datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package median_pkg;

   // Default pixel width and window geometry
   localparam int DW   = 8;
   localparam int WIN  = 5;
   localparam int NPIX = WIN * WIN;

   // One pixel and one full 5x5 window (element k-1 holds pix k)
   typedef logic [DW-1:0] pix_t;
   typedef pix_t [NPIX-1:0] win_t;

   // Low bit of pix k (k = 1..25) in a flat window bus of dw-bit pixels
   function automatic int pix_lo(input int k, input int dw);
      return (k - 1) * dw;
   endfunction

   // Window row (0 = oldest line) holding pix k
   function automatic int pix_row(input int k);
      return (k - 1) / WIN;
   endfunction

   // Window column (0 = leftmost, column c-4) holding pix k
   function automatic int pix_col(input int k);
      return (k - 1) % WIN;
   endfunction

endpackage

// File: rtl/line_delay.sv
// One-line pixel delay: DEPTH-entry memory addressed by column.
// Latency: read is combinational at addr; write lands on the enabled edge.
// Backpressure: none; en gates the write so stalls leave contents untouched.
module line_delay #(
   parameter int DEPTH = 640,
   parameter int DW    = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [DEPTH];

   // Old contents are visible before the edge that overwrites them,
   // so dout is the pixel one line above the incoming one.
   assign dout = mem[addr];

   // Store the incoming pixel on accepted beats only; contents are never reset
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= din;
      end
   end

endmodule

// File: rtl/window_gen_5x5.sv
// Builds a 5x5 raster window from four line delays plus a 5x5 shift register.
// Latency: 1 clk from the accepting edge to win_valid; all outputs registered.
// Backpressure: none; every in_valid beat is accepted, in_valid low freezes state.
module window_gen_5x5 #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DW    = median_pkg::DW,
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [DW-1:0]       in_pix,
   output logic                win_valid,
   output logic [25*DW-1:0]    win_pix,
   output logic [XW-1:0]       win_x,
   output logic [YW-1:0]       win_y,
   output logic                win_last
);

   import median_pkg::WIN;
   import median_pkg::NPIX;
   import median_pkg::pix_lo;
   import median_pkg::pix_row;
   import median_pkg::pix_col;

   localparam int NLB = WIN - 1;

   // Position of the next pixel to be accepted
   logic [XW-1:0] col;
   logic [YW-1:0] row;

   // Position of the pixel on the input this cycle (in_sof forces 0,0)
   logic [XW-1:0] cur_col;
   logic [YW-1:0] cur_row;
   logic          at_end_col;
   logic          at_end_row;
   logic          emit;

   // Line delay chain and the column entering the window on this beat
   logic [DW-1:0] lb_in   [NLB];
   logic [DW-1:0] lb_out  [NLB];
   logic [DW-1:0] new_col [WIN];

   // Window registers: win_r[r][c], r = 0 is the oldest line, c = 0 is column c-4
   logic [DW-1:0] win_r [WIN][WIN];

   // Resolve the current pixel position and whether it completes a window
   always_comb begin
      cur_col    = in_sof ? '0 : col;
      cur_row    = in_sof ? '0 : row;
      at_end_col = (cur_col == XW'(IMG_W - 1));
      at_end_row = (cur_row == YW'(IMG_H - 1));
      emit       = in_valid
                   && (cur_col >= XW'(WIN - 1))
                   && (cur_row >= YW'(WIN - 1));
   end

   // Chain the delay lines: in_pix -> lb0 -> lb1 -> lb2 -> lb3
   always_comb begin
      for (int k = 0; k < NLB; k++) begin
         lb_in[k] = '0;
      end
      lb_in[0] = in_pix;
      for (int k = 1; k < NLB; k++) begin
         lb_in[k] = lb_out[k-1];
      end
   end

   for (genvar k = 0; k < NLB; k++) begin : g_lb
      line_delay #(
         .DEPTH (IMG_W),
         .DW    (DW),
         .AW    (XW)
      ) u_lb (
         .clk  (clk),
         .en   (in_valid),
         .addr (cur_col),
         .din  (lb_in[k]),
         .dout (lb_out[k])
      );
   end

   // New right-hand column: deepest delay line feeds the oldest window row
   always_comb begin
      for (int r = 0; r < WIN; r++) begin
         new_col[r] = '0;
      end
      for (int r = 0; r < NLB; r++) begin
         new_col[r] = lb_out[NLB-1-r];
      end
      new_col[WIN-1] = in_pix;
   end

   // Raster counters: advance from the resolved position on every accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (at_end_col) begin
            col <= '0;
            row <= at_end_row ? '0 : cur_row + YW'(1);
         end else begin
            col <= cur_col + XW'(1);
            row <= cur_row;
         end
      end
   end

   // Window shift: every row moves left one column and takes its new pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
               win_r[r][c] <= '0;
            end
         end
      end else if (in_valid) begin
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
               win_r[r][c] <= win_r[r][c+1];
            end
            win_r[r][WIN-1] <= new_col[r];
         end
      end
   end

   // Window strobe and centre coordinates; coordinates hold between windows
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         win_x     <= '0;
         win_y     <= '0;
      end else begin
         win_valid <= emit;
         win_last  <= emit && at_end_col && at_end_row;
         if (emit) begin
            win_x <= cur_col - XW'(2);
            win_y <= cur_row - YW'(2);
         end
      end
   end

   // Flatten the window registers into pix1..pix25 order
   always_comb begin
      win_pix = '0;
      for (int k = 1; k <= NPIX; k++) begin
         win_pix[pix_lo(k, DW) +: DW] = win_r[pix_row(k)][pix_col(k)];
      end
   end

endmodule

// File: tb/tb_window_gen_5x5.sv
// Randomized bench for window_gen_5x5 on an 8x6 ramp image.
// Latency: expects each window exactly one clock after the accepting edge.
// Backpressure: random in_valid gaps; no ready path exists.
module tb_window_gen_5x5;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 8;
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);
   localparam int NB = 25 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_sof;
   logic [DW-1:0] in_pix;
   logic          win_valid;
   logic [NB-1:0] win_pix;
   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;
   logic          win_last;

   window_gen_5x5 #(
      .IMG_W (W),
      .IMG_H (H),
      .DW    (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pix    (in_pix),
      .win_valid (win_valid),
      .win_pix   (win_pix),
      .win_x     (win_x),
      .win_y     (win_y),
      .win_last  (win_last)
   );

   always #5 clk = ~clk;

   // Reference image of the frame currently being sent, indexed [y][x]
   logic [DW-1:0] img [H][W];

   int n_chk  = 0;
   int n_fail = 0;

   // Per-frame bookkeeping taken from observed windows
   int            win_cnt;
   int            last_cnt;
   bit            have_first;
   logic [NB-1:0] first_win;
   int            first_x;
   int            first_y;
   int            first_acc;
   int            lw_x;
   int            lw_y;
   int            lw_pix25;
   int            hold_x = 0;
   int            hold_y = 0;

   task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected window centred at (x-2, y-2), straight from the image array
   function automatic logic [NB-1:0] exp_window(input int x, input int y);
      logic [NB-1:0] v;
      v = '0;
      for (int k = 0; k < 25; k++) begin
         v[k*DW +: DW] = img[y - 4 + k / 5][x - 4 + k % 5];
      end
      return v;
   endfunction

   // Drive one cycle; if v, the pixel is frame position (x, y)
   task automatic beat(input bit v, input bit sof, input logic [DW-1:0] p, input int x, input int y);
      bit exp_win;
      in_valid = v;
      in_sof   = sof;
      in_pix   = p;
      if (v) img[y][x] = p;
      exp_win = v && (x >= 4) && (y >= 4);
      @(posedge clk);
      #1;
      if (win_valid) begin
         win_cnt++;
         if (win_last) last_cnt++;
         lw_x     = int'(win_x);
         lw_y     = int'(win_y);
         lw_pix25 = int'(win_pix[NB-1 -: DW]);
         if (!have_first) begin
            have_first = 1'b1;
            first_win  = win_pix;
            first_x    = int'(win_x);
            first_y    = int'(win_y);
            first_acc  = int'(p);
         end
      end
      if (exp_win) begin
         chk("win_valid", NB'(win_valid), NB'(1));
         chk("win_x", NB'(win_x), NB'(x - 2));
         chk("win_y", NB'(win_y), NB'(y - 2));
         chk("win_last", NB'(win_last), NB'((x == W - 1) && (y == H - 1)));
         chk("win_pix", win_pix, exp_window(x, y));
         hold_x = x - 2;
         hold_y = y - 2;
      end else begin
         chk("no_window", NB'(win_valid), NB'(0));
         if (!v) begin
            chk("hold_x", NB'(win_x), NB'(hold_x));
            chk("hold_y", NB'(win_y), NB'(hold_y));
         end
      end
   endtask

   // Send the first n_pix pixels of a ramp frame (offset + 16*y + x)
   task automatic send_frame(input int off, input bit sof, input int idle_pct, input int n_pix);
      win_cnt    = 0;
      last_cnt   = 0;
      have_first = 1'b0;
      for (int yy = 0; yy < H; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            img[yy][xx] = 'x;
         end
      end
      for (int i = 0; i < n_pix; i++) begin
         for (int g = 0; g < 6 && $urandom_range(99) < idle_pct; g++) begin
            beat(1'b0, 1'($urandom_range(1)), DW'($urandom), 0, 0);
         end
         beat(1'b1, sof && (i == 0), DW'(off + 16 * (i / W) + (i % W)), i % W, i / W);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, NB'(win_valid), NB'(0));
      chk({tag, "_x"}, NB'(win_x), NB'(0));
      chk({tag, "_y"}, NB'(win_y), NB'(0));
      chk({tag, "_last"}, NB'(win_last), NB'(0));
      chk({tag, "_pix"}, win_pix, NB'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pix   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Continuous ramp frame
      send_frame(0, 1'b1, 0, W * H);
      chk("t1_count", NB'(win_cnt), NB'(8));
      chk("t1_last_count", NB'(last_cnt), NB'(1));
      chk("t1_first_after_pix", NB'(first_acc), NB'(8'h44));
      chk("t1_first_x", NB'(first_x), NB'(2));
      chk("t1_first_y", NB'(first_y), NB'(2));
      chk("t1_pix1", NB'(first_win[7:0]), NB'(8'h00));
      chk("t1_pix5", NB'(first_win[39:32]), NB'(8'h04));
      chk("t1_pix13", NB'(first_win[103:96]), NB'(8'h22));
      chk("t1_pix21", NB'(first_win[167:160]), NB'(8'h40));
      chk("t1_pix25", NB'(first_win[199:192]), NB'(8'h44));
      chk("t1_last_x", NB'(lw_x), NB'(5));
      chk("t1_last_y", NB'(lw_y), NB'(3));
      chk("t1_last_pix25", NB'(lw_pix25), NB'(8'h57));

      // Same ramp with random gaps
      send_frame(0, 1'b1, 40, W * H);
      chk("t2_count", NB'(win_cnt), NB'(8));
      chk("t2_last_count", NB'(last_cnt), NB'(1));

      // Reset in the middle of row 4, then restart without in_sof
      send_frame(0, 1'b1, 30, 4 * W + 6);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'($urandom_range(1));
         in_sof   = 1'b0;
         in_pix   = DW'($urandom);
         @(posedge clk);
         #1;
         chk_reset_outputs("in_reset");
      end
      rst    = 1'b0;
      hold_x = 0;
      hold_y = 0;
      send_frame(0, 1'b0, 20, W * H);
      chk("t3_count", NB'(win_cnt), NB'(8));
      chk("t3_pix1", NB'(first_win[7:0]), NB'(8'h00));
      chk("t3_pix25", NB'(first_win[199:192]), NB'(8'h44));

      // in_sof while the old position is (3,4)
      send_frame(8'h20, 1'b1, 0, 4 * W + 3);
      send_frame(0, 1'b1, 25, W * H);
      chk("t4_count", NB'(win_cnt), NB'(8));
      chk("t4_first_x", NB'(first_x), NB'(2));
      chk("t4_first_y", NB'(first_y), NB'(2));
      chk("t4_pix25", NB'(first_win[199:192]), NB'(8'h44));

      // Two back-to-back frames, second one relying on counter wrap
      send_frame(8'h10, 1'b1, 20, W * H);
      chk("t5a_count", NB'(win_cnt), NB'(8));
      chk("t5a_last_count", NB'(last_cnt), NB'(1));
      send_frame(8'h80, 1'b0, 20, W * H);
      chk("t5b_count", NB'(win_cnt), NB'(8));
      chk("t5b_last_count", NB'(last_cnt), NB'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
